// File: rtl/seven_seg_sequence_monitor.sv
// seven_seg_sequence_monitor
// Watches the 7-segment pattern produced by the UP/DOWN sequence counter
// (5,0,8,4,1,3,8,9,2), decodes it back to BCD, tracks the sequence position
// and pulses ERR on any transition the counter cannot legally make.
// Optional feature: define SEQ_MON_ERRCNT_EN to build the saturating error
// counter on ERR_CNT; otherwise ERR_CNT is tied to zero.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_SEARCH   | position unknown, waiting for a 5 (sequence start)
// ST_LOCKED   | synchronised, POS tracks the counter position
// ST_BLANKED  | display blanked, only blank or a restart at 5 is legal

module seven_seg_sequence_monitor #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 TICK,
  input  logic [6:0]           SEG,
  output logic [3:0]           DIGIT,
  output logic [3:0]           POS,
  output logic                 LOCKED,
  output logic [1:0]           DIR,
  output logic                 EVT,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_BLANKED = 2'd2
  } state_t;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_INVAL = 4'hE;
  localparam logic [1:0] DIR_HOLD  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_NONE  = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic [3:0] pos_q, pos_d;
  logic       locked_q, locked_d;
  logic [1:0] dir_q, dir_d;
  logic       evt_q, evt_d;
  logic       err_q, err_d;

  logic [6:0] seg_al;
  logic [3:0] dec;
  logic [3:0] pos_inc, pos_dec;

  function automatic logic [3:0] seq_at(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:    v = 4'd5;
      4'd1:    v = 4'd0;
      4'd2:    v = 4'd8;
      4'd3:    v = 4'd4;
      4'd4:    v = 4'd1;
      4'd5:    v = 4'd3;
      4'd6:    v = 4'd8;
      4'd7:    v = 4'd9;
      4'd8:    v = 4'd2;
      default: v = DIG_INVAL;
    endcase
    return v;
  endfunction

  // Normalise polarity to active-low and decode the pattern to BCD/blank/invalid
  always_comb begin
    seg_al = SEG_ACTIVE_LOW ? SEG : ~SEG;
    case (seg_al)
      7'b0000001: dec = 4'd0;
      7'b1001111: dec = 4'd1;
      7'b0010010: dec = 4'd2;
      7'b0000110: dec = 4'd3;
      7'b1001100: dec = 4'd4;
      7'b0100100: dec = 4'd5;
      7'b0100000: dec = 4'd6;
      7'b0001111: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0000100: dec = 4'd9;
      7'b1111111: dec = DIG_BLANK;
      default:    dec = DIG_INVAL;
    endcase
  end

  // Neighbouring positions with wrap across the 9-entry sequence
  always_comb begin
    pos_inc = (pos_q == 4'd8) ? 4'd0 : pos_q + 4'd1;
    pos_dec = (pos_q == 4'd0) ? 4'd8 : pos_q - 4'd1;
  end

  // Next-state and output computation; only a TICK causes any processing
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    evt_d   = 1'b0;
    err_d   = 1'b0;
    if (TICK) begin
      evt_d   = 1'b1;
      digit_d = dec;
      case (state_q)
        ST_SEARCH: begin
          // Unknown position: nothing but a 5 or blank can be judged
          if (dec == 4'd5) begin
            state_d = ST_LOCKED;
            pos_d   = 4'd0;
            dir_d   = DIR_NONE;
          end else if (dec == DIG_BLANK) begin
            state_d = ST_BLANKED;
            dir_d   = DIR_NONE;
          end
        end
        ST_LOCKED: begin
          if (dec == seq_at(pos_q)) begin
            dir_d = DIR_HOLD;
          end else if (dec == seq_at(pos_inc)) begin
            pos_d = pos_inc;
            dir_d = DIR_UP;
          end else if (dec == seq_at(pos_dec)) begin
            pos_d = pos_dec;
            dir_d = DIR_DOWN;
          end else if (dec == DIG_BLANK) begin
            state_d = ST_BLANKED;
            dir_d   = DIR_NONE;
          end else begin
            state_d = ST_SEARCH;
            dir_d   = DIR_NONE;
            err_d   = 1'b1;
          end
        end
        ST_BLANKED: begin
          if (dec == 4'd5) begin
            state_d = ST_LOCKED;
            pos_d   = 4'd0;
            dir_d   = DIR_NONE;
          end else if (dec != DIG_BLANK) begin
            state_d = ST_SEARCH;
            dir_d   = DIR_NONE;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          dir_d   = DIR_NONE;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_SEARCH;
      digit_q  <= DIG_BLANK;
      pos_q    <= 4'd0;
      locked_q <= 1'b0;
      dir_q    <= DIR_NONE;
      evt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      pos_q    <= pos_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      evt_q    <= evt_d;
      err_q    <= err_d;
    end
  end

`ifdef SEQ_MON_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of ERR pulses, stops at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  end

  // Error counter register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = '0;
`endif

  assign DIGIT  = digit_q;
  assign POS    = pos_q;
  assign LOCKED = locked_q;
  assign DIR    = dir_q;
  assign EVT    = evt_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_seven_seg_sequence_monitor.sv
// Directed bench for seven_seg_sequence_monitor with a reference model feeding
// an expected-result queue; entries are popped when the DUT output appears.
// Expected ERR_CNT follows SEQ_MON_ERRCNT_EN the same way as the design build.

module tb_seven_seg_sequence_monitor;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       TICK;
  logic [6:0] SEG;
  logic [3:0] DIGIT;
  logic [3:0] POS;
  logic       LOCKED;
  logic [1:0] DIR;
  logic       EVT;
  logic       ERR;
  logic [7:0] ERR_CNT;

  seven_seg_sequence_monitor #(.SEG_ACTIVE_LOW(1'b1), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .SEG(SEG),
    .DIGIT(DIGIT), .POS(POS), .LOCKED(LOCKED), .DIR(DIR),
    .EVT(EVT), .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] digit;
    logic [3:0] pos;
    logic       locked;
    logic [1:0] dir;
    logic       evt;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model state: 0 search, 1 locked, 2 blanked
  int         m_state;
  int         m_pos;
  logic [1:0] m_dir;
  logic [3:0] m_digit;
  int         m_cnt;
  int         seq_rom[9] = '{5, 0, 8, 4, 1, 3, 8, 9, 2};
  logic [6:0] bad_pat = 7'b1010101;

  function automatic logic [6:0] enc(int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int model_dec(logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (enc(i) == s) return i;
    if (s == 7'b1111111) return 15;
    return 14;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_dir = 2'b11; m_digit = 4'hF; m_cnt = 0;
  endtask

  task automatic model_step(logic [6:0] s);
    int d;
    logic e;
    exp_t x;
    d = model_dec(s);
    e = 1'b0;
    m_digit = d[3:0];
    if (m_state == 1) begin
      if (d == seq_rom[m_pos]) m_dir = 2'b00;
      else if (d == seq_rom[(m_pos + 1) % 9]) begin m_pos = (m_pos + 1) % 9; m_dir = 2'b01; end
      else if (d == seq_rom[(m_pos + 8) % 9]) begin m_pos = (m_pos + 8) % 9; m_dir = 2'b10; end
      else if (d == 15) begin m_state = 2; m_dir = 2'b11; end
      else begin m_state = 0; m_dir = 2'b11; e = 1'b1; end
    end else begin
      if (d == 5) begin m_state = 1; m_pos = 0; m_dir = 2'b11; end
      else if (d == 15) begin m_state = 2; m_dir = 2'b11; end
      else if (m_state == 2) begin m_state = 0; m_dir = 2'b11; e = 1'b1; end
    end
`ifdef SEQ_MON_ERRCNT_EN
    if (e && m_cnt < 255) m_cnt++;
`endif
    x.digit = m_digit; x.pos = m_pos[3:0]; x.locked = (m_state == 1);
    x.dir = m_dir; x.evt = 1'b1; x.err = e; x.cnt = m_cnt[7:0];
    sb.push_back(x);
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb();
    exp_t x;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("digit",  {4'h0, DIGIT},  {4'h0, x.digit});
      chk("pos",    {4'h0, POS},    {4'h0, x.pos});
      chk("locked", {7'h0, LOCKED}, {7'h0, x.locked});
      chk("dir",    {6'h0, DIR},    {6'h0, x.dir});
      chk("evt",    {7'h0, EVT},    {7'h0, x.evt});
      chk("err",    {7'h0, ERR},    {7'h0, x.err});
      chk("errcnt", ERR_CNT,        x.cnt);
    end
  endtask

  // called at a falling edge: drives one sample, checks it at the next falling edge
  task automatic tick(logic [6:0] s);
    SEG  = s;
    TICK = 1'b1;
    model_step(s);
    @(negedge CLK);
    TICK = 1'b0;
    check_sb();
  endtask

  task automatic idle_check();
    @(negedge CLK);
    chk("idle_evt", {7'h0, EVT}, 8'h00);
    chk("idle_err", {7'h0, ERR}, 8'h00);
  endtask

  task automatic reset_values(string tag);
    chk({tag, "_digit"},  {4'h0, DIGIT},  8'h0F);
    chk({tag, "_pos"},    {4'h0, POS},    8'h00);
    chk({tag, "_locked"}, {7'h0, LOCKED}, 8'h00);
    chk({tag, "_dir"},    {6'h0, DIR},    8'h03);
    chk({tag, "_evt"},    {7'h0, EVT},    8'h00);
    chk({tag, "_err"},    {7'h0, ERR},    8'h00);
    chk({tag, "_errcnt"}, ERR_CNT,        8'h00);
  endtask

  initial begin
    RESET = 1'b1; TICK = 1'b0; SEG = 7'b1111111;
    model_reset();
    #12;
    reset_values("rst");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: full upward pass with wrap, back-to-back ticks
    tick(enc(5));
    chk("t1_locked_first", {7'h0, LOCKED}, 8'h01);
    for (int i = 1; i < 9; i++) tick(enc(seq_rom[i]));
    chk("t1_pos_end", {4'h0, POS}, 8'h08);
    tick(enc(5));
    chk("t1_pos_wrap", {4'h0, POS}, 8'h00);
    chk("t1_dir_wrap", {6'h0, DIR}, 8'h01);
    idle_check();

    // 2: step down across the wrap, then hold
    @(negedge CLK);
    tick(enc(2));
    chk("t2_pos_down", {4'h0, POS}, 8'h08);
    chk("t2_dir_down", {6'h0, DIR}, 8'h02);
    tick(enc(2));
    chk("t2_dir_hold", {6'h0, DIR}, 8'h00);
    tick(enc(5));

    // 3: illegal jump from POS=3, recovery through search
    tick(enc(0)); tick(enc(8)); tick(enc(4));
    chk("t3_pos3", {4'h0, POS}, 8'h03);
    tick(enc(9));
    chk("t3_err", {7'h0, ERR}, 8'h01);
    chk("t3_unlock", {7'h0, LOCKED}, 8'h00);
`ifdef SEQ_MON_ERRCNT_EN
    chk("t3_errcnt", ERR_CNT, 8'h01);
`else
    chk("t3_errcnt", ERR_CNT, 8'h00);
`endif
    idle_check();
    tick(enc(0));
    chk("t3_search_noerr", {7'h0, ERR}, 8'h00);
    tick(enc(5));
    chk("t3_relock", {7'h0, LOCKED}, 8'h01);
    chk("t3_relock_pos", {4'h0, POS}, 8'h00);

    // 4: blanking, illegal exit, legal exit at 5
    tick(7'b1111111);
    chk("t4_blank_digit", {4'h0, DIGIT}, 8'h0F);
    chk("t4_blank_unlock", {7'h0, LOCKED}, 8'h00);
    tick(7'b1111111);
    chk("t4_blank_noerr", {7'h0, ERR}, 8'h00);
    tick(enc(8));
    chk("t4_blank_err", {7'h0, ERR}, 8'h01);
    tick(enc(5)); tick(7'b1111111); tick(7'b1111111);
    tick(enc(5));
    chk("t4_blank_relock", {7'h0, LOCKED}, 8'h01);
    chk("t4_blank_noerr5", {7'h0, ERR}, 8'h00);

    // 5: invalid pattern, then drive the error count past saturation
    tick(bad_pat);
    chk("t5_inval_digit", {4'h0, DIGIT}, 8'h0E);
    chk("t5_inval_err", {7'h0, ERR}, 8'h01);
    for (int i = 0; i < 299; i++) begin
      tick(enc(5));
      tick(bad_pat);
    end
`ifdef SEQ_MON_ERRCNT_EN
    chk("t5_errcnt_sat", ERR_CNT, 8'hFF);
`else
    chk("t5_errcnt_off", ERR_CNT, 8'h00);
`endif

    // 6: reset during a tick at POS=5
    for (int i = 0; i < 6; i++) tick(enc(seq_rom[i]));
    chk("t6_pos5", {4'h0, POS}, 8'h05);
    SEG = enc(8); TICK = 1'b1; RESET = 1'b1;
    #1;
    reset_values("t6_async");
    @(negedge CLK);
    RESET = 1'b0; TICK = 1'b0;
    model_reset();
    reset_values("t6_held");
    tick(enc(3));
    chk("t6_nolock", {7'h0, LOCKED}, 8'h00);
    chk("t6_noerr", {7'h0, ERR}, 8'h00);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
